// File: rtl/bp_axis_bridge_pkg.sv
// Shared definitions for bp_axis_bridge: flit field helpers, pointer-width helper
// and the egress skid occupancy encoding.
package bp_axis_bridge_pkg;

    // Flit layout is {last, addr, data}
    function automatic int unsigned flit_w(input int unsigned a_w, input int unsigned d_w);
        return a_w + d_w + 1;
    endfunction

    function automatic int unsigned last_idx(input int unsigned a_w, input int unsigned d_w);
        return a_w + d_w;
    endfunction

    function automatic int unsigned addr_lo(input int unsigned d_w);
        return d_w;
    endfunction

    function automatic int unsigned data_hi(input int unsigned d_w);
        return d_w - 1;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/bp_skid2.sv
// Two-entry registered skid: client valid/backpressure in, AXIS-style valid/ready out.
module bp_skid2
    import bp_axis_bridge_pkg::*;
#(
    parameter int unsigned FW = 35
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [FW-1:0] in_d,
    input  logic          in_v,
    output logic          in_b,
    output logic [FW-1:0] out_d,
    output logic          out_v,
    input  logic          out_r
);

    skid_state_e   state_q, state_d;
    logic [FW-1:0] main_q;
    logic [FW-1:0] skid_q;
    logic          accept;
    logic          drain;
    logic          load_main;
    logic          load_skid;
    logic          main_from_skid;

    // Backpressure is the registered skid occupancy; ce=0 also stalls the client
    assign in_b   = (state_q == SKID_TWO) | ~ce;
    assign out_v  = (state_q != SKID_EMPTY) & ce;
    assign out_d  = (state_q != SKID_EMPTY) ? main_q : '0;
    assign accept = in_v & ~in_b;
    assign drain  = out_v & out_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SKID_EMPTY;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = SKID_TWO;
                end else if (drain) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (drain) begin
                    main_from_skid = 1'b1;
                    state_d        = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Payload registers are unreset; contents are qualified by state_q
    always_ff @(posedge clk) begin
        if (load_main) begin
            main_q <= in_d;
        end else if (main_from_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_d;
        end
    end

endmodule

// File: rtl/bp_axis_bridge.sv
// AXIS <-> valid/backpressure bridge: ingress FIFO, egress 2-entry skid, packet-length check.
// Optional statistics outputs are enabled with BP_BRIDGE_STATS_EN.
module bp_axis_bridge
    import bp_axis_bridge_pkg::*;
#(
    parameter int unsigned D_W     = 32,
    parameter int unsigned A_W     = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_PKT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic [A_W+D_W-1:0]             s_axis_wdata,
    input  logic                           s_axis_wvalid,
    input  logic                           s_axis_wlast,
    output logic                           s_axis_wready,
    output logic [A_W+D_W:0]               o_d,
    output logic                           o_v,
    input  logic                           o_b,
    input  logic [A_W+D_W:0]               i_d,
    input  logic                           i_v,
    output logic                           i_b,
    output logic [A_W+D_W-1:0]             m_axis_wdata,
    output logic                           m_axis_wvalid,
    output logic                           m_axis_wlast,
    input  logic                           m_axis_wready,
    output logic                           pkt_err
`ifdef BP_BRIDGE_STATS_EN
    ,
    output logic [31:0]                    in_flits,
    output logic [31:0]                    out_flits,
    output logic [ptr_w(DEPTH):0]          hwm
`endif
);

    localparam int unsigned FW    = flit_w(A_W, D_W);
    localparam int unsigned LAST  = last_idx(A_W, D_W);
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned PKT_W = $clog2(MAX_PKT + 1);

    logic [FW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PKT_W-1:0] pkt_cnt_q;
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;
    logic [FW-1:0]    eg_d;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign empty         = (count_q == '0);
    assign s_axis_wready = ce & ~full & ~rst;
    assign o_v           = ce & ~empty;
    assign o_d           = mem[rd_ptr_q];
    assign wr_en         = s_axis_wvalid & s_axis_wready;
    assign rd_en         = o_v & ~o_b;

    // Ingress FIFO control
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {s_axis_wlast, s_axis_wdata};
        end
    end

    // Packet length tracking; counter saturates at MAX_PKT so it never wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
            pkt_err   <= 1'b0;
        end else if (wr_en) begin
            if (s_axis_wlast) begin
                pkt_cnt_q <= '0;
            end else begin
                if (pkt_cnt_q == PKT_W'(MAX_PKT)) begin
                    pkt_err <= 1'b1;
                end else begin
                    pkt_cnt_q <= pkt_cnt_q + PKT_W'(1);
                end
            end
        end
    end

    bp_skid2 #(
        .FW (FW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .in_d  (i_d),
        .in_v  (i_v),
        .in_b  (i_b),
        .out_d (eg_d),
        .out_v (m_axis_wvalid),
        .out_r (m_axis_wready)
    );

    assign m_axis_wlast = eg_d[LAST];
    assign m_axis_wdata = eg_d[LAST-1:0];

`ifdef BP_BRIDGE_STATS_EN
    // Saturating flit counters and ingress occupancy high-water mark
    always_ff @(posedge clk) begin
        if (rst) begin
            in_flits  <= '0;
            out_flits <= '0;
            hwm       <= '0;
        end else begin
            if (wr_en && (in_flits != '1)) begin
                in_flits <= in_flits + 32'd1;
            end
            if (m_axis_wvalid && m_axis_wready && (out_flits != '1)) begin
                out_flits <= out_flits + 32'd1;
            end
            if (count_q > hwm) begin
                hwm <= count_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_axis_bridge.sv
// Self-checking bench for bp_axis_bridge: queue-based reference model, directed phases
// followed by a randomized run.
module tb_bp_axis_bridge;

    localparam int unsigned D_W     = 32;
    localparam int unsigned A_W     = 2;
    localparam int unsigned FW      = A_W + D_W + 1;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_PKT = 16;

    typedef logic [FW-1:0] flit_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic [A_W+D_W-1:0] s_axis_wdata;
    logic               s_axis_wvalid;
    logic               s_axis_wlast;
    logic               s_axis_wready;
    logic [FW-1:0]      o_d;
    logic               o_v;
    logic               o_b;
    logic [FW-1:0]      i_d;
    logic               i_v;
    logic               i_b;
    logic [A_W+D_W-1:0] m_axis_wdata;
    logic               m_axis_wvalid;
    logic               m_axis_wlast;
    logic               m_axis_wready;
    logic               pkt_err;

    always #5 clk = ~clk;

    bp_axis_bridge #(
        .D_W     (D_W),
        .A_W     (A_W),
        .DEPTH   (DEPTH),
        .MAX_PKT (MAX_PKT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .s_axis_wdata  (s_axis_wdata),
        .s_axis_wvalid (s_axis_wvalid),
        .s_axis_wlast  (s_axis_wlast),
        .s_axis_wready (s_axis_wready),
        .o_d           (o_d),
        .o_v           (o_v),
        .o_b           (o_b),
        .i_d           (i_d),
        .i_v           (i_v),
        .i_b           (i_b),
        .m_axis_wdata  (m_axis_wdata),
        .m_axis_wvalid (m_axis_wvalid),
        .m_axis_wlast  (m_axis_wlast),
        .m_axis_wready (m_axis_wready),
        .pkt_err       (pkt_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Sources, reference model contents and delivered/expected sequences
    flit_t src_in[$], src_eg[$];
    flit_t mdl_in[$], mdl_eg[$];
    flit_t sent_in[$], got_in[$], sent_eg[$], got_eg[$];
    int    mdl_cnt = 0;
    bit    mdl_err = 1'b0;
    bit    in_hold = 1'b0;
    bit    eg_hold = 1'b0;

    bit rst_k = 1'b1;
    bit ce_k  = 1'b1;
    int gap_pct = 0;
    int ob_pct  = 100;
    int mr_pct  = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input flit_t obs, input flit_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic flit_t rand_flit(input int last_pct);
        flit_t f;
        f = FW'({$urandom(), $urandom()});
        f[FW-1] = ($urandom_range(99) < last_pct);
        return f;
    endfunction

    // One clock: drive, compare outputs to the model, clock, advance the model
    task automatic cycle();
        bit    exp_rdy, exp_ov, exp_ib, exp_mv;
        bit    in_acc, rd, eg_acc, drn;
        flit_t od_s, md_s, f;

        rst = rst_k;
        ce  = ce_k;
        o_b = ($urandom_range(99) < ob_pct);
        m_axis_wready = ($urandom_range(99) < mr_pct);
        if (src_in.size() > 0 && (in_hold || $urandom_range(99) >= gap_pct)) begin
            s_axis_wvalid = 1'b1;
            {s_axis_wlast, s_axis_wdata} = src_in[0];
        end else begin
            s_axis_wvalid = 1'b0;
        end
        if (src_eg.size() > 0 && (eg_hold || $urandom_range(99) >= gap_pct)) begin
            i_v = 1'b1;
            i_d = src_eg[0];
        end else begin
            i_v = 1'b0;
        end
        #1;
        exp_rdy = ce && !rst && (mdl_in.size() < DEPTH);
        exp_ov  = ce && (mdl_in.size() > 0);
        exp_ib  = !ce || (mdl_eg.size() == 2);
        exp_mv  = ce && (mdl_eg.size() > 0);
        chk1("s_axis_wready", s_axis_wready, exp_rdy);
        chk1("o_v", o_v, exp_ov);
        if (exp_ov) chkf("o_d", o_d, mdl_in[0]);
        chk1("i_b", i_b, exp_ib);
        chk1("m_axis_wvalid", m_axis_wvalid, exp_mv);
        if (exp_mv) chkf("m_axis_flit", {m_axis_wlast, m_axis_wdata}, mdl_eg[0]);
        chk1("pkt_err", pkt_err, mdl_err);
        od_s   = o_d;
        md_s   = {m_axis_wlast, m_axis_wdata};
        in_acc = s_axis_wvalid && exp_rdy;
        rd     = exp_ov && !o_b && !rst;
        eg_acc = i_v && !exp_ib && !rst;
        drn    = exp_mv && m_axis_wready && !rst;
        @(posedge clk);
        if (rst) begin
            repeat (mdl_in.size()) void'(sent_in.pop_back());
            repeat (mdl_eg.size()) void'(sent_eg.pop_back());
            mdl_in.delete();
            mdl_eg.delete();
            mdl_cnt = 0;
            mdl_err = 1'b0;
            in_hold = 1'b0;
            eg_hold = 1'b0;
        end else begin
            if (rd) begin
                got_in.push_back(od_s);
                void'(mdl_in.pop_front());
            end
            if (in_acc) begin
                f = src_in.pop_front();
                if (mdl_cnt >= MAX_PKT && !f[FW-1]) mdl_err = 1'b1;
                mdl_cnt = f[FW-1] ? 0 : mdl_cnt + 1;
                mdl_in.push_back(f);
                sent_in.push_back(f);
            end
            if (drn) begin
                got_eg.push_back(md_s);
                void'(mdl_eg.pop_front());
            end
            if (eg_acc) begin
                f = src_eg.pop_front();
                mdl_eg.push_back(f);
                sent_eg.push_back(f);
            end
            in_hold = s_axis_wvalid && !in_acc;
            eg_hold = i_v && !eg_acc;
        end
        #1;
    endtask

    // Run until sources and model drain, bounded
    task automatic drain_all(input string tag);
        int budget = 200;
        ce_k = 1'b1; ob_pct = 0; mr_pct = 100; gap_pct = 0;
        while ((src_in.size() + src_eg.size() + mdl_in.size() + mdl_eg.size()) > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        chki({tag, "_drained"}, src_in.size() + src_eg.size() + mdl_in.size() + mdl_eg.size(), 0);
    endtask

    task automatic seq_check(input string tag);
        chki({tag, "_in_len"}, got_in.size(), sent_in.size());
        for (int k = 0; k < got_in.size() && k < sent_in.size(); k++)
            chkf({tag, "_in_seq"}, got_in[k], sent_in[k]);
        chki({tag, "_eg_len"}, got_eg.size(), sent_eg.size());
        for (int k = 0; k < got_eg.size() && k < sent_eg.size(); k++)
            chkf({tag, "_eg_seq"}, got_eg[k], sent_eg[k]);
        got_in.delete(); sent_in.delete(); got_eg.delete(); sent_eg.delete();
    endtask

    initial begin
        flit_t f;
        int    n0;
        rst = 1'b1; ce = 1'b1; o_b = 1'b1; m_axis_wready = 1'b0;
        s_axis_wvalid = 1'b0; s_axis_wlast = 1'b0; s_axis_wdata = '0;
        i_v = 1'b0; i_d = '0;
        @(posedge clk);
        #1;

        // Reset held with ingress valid asserted; fill flits A0..A4 queued upstream
        for (int k = 0; k < 5; k++) begin
            f = FW'(32'hA0 + 32'(k));
            f[D_W +: A_W] = A_W'(k);
            f[FW-1] = (k == 1 || k == 4);
            src_in.push_back(f);
        end
        rst_k = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        chk1("rst_release_ready", s_axis_wready, 1'b1);
        rst_k = 1'b0;

        // Fill with o_b=1: four accepted, ready drops, fifth held upstream
        repeat (6) cycle();
        chk1("full_ready_low", s_axis_wready, 1'b0);
        chkf("full_head", o_d, {1'b0, A_W'(0), 32'hA0});
        chki("full_held_upstream", src_in.size(), 1);
        ob_pct = 0;
        repeat (8) cycle();
        chki("fill_delivered", got_in.size(), 5);
        seq_check("fill");

        // Streaming at one flit per cycle
        for (int k = 0; k < 20; k++) src_in.push_back(rand_flit(10));
        n0 = got_in.size();
        repeat (21) cycle();
        chki("stream_rate", got_in.size() - n0, 20);
        drain_all("stream");
        seq_check("stream");

        // Egress backpressure: third client flit held until ready rises
        mr_pct = 0;
        for (int k = 0; k < 3; k++) src_eg.push_back(rand_flit(50));
        repeat (3) cycle();
        chk1("eg_bp_high", i_b, 1'b1);
        chki("eg_third_held", src_eg.size(), 1);
        mr_pct = 100;
        repeat (5) cycle();
        seq_check("egress");

        // Clock-enable freeze mid-stream in both directions
        for (int k = 0; k < 16; k++) begin
            src_in.push_back(rand_flit(25));
            src_eg.push_back(rand_flit(25));
        end
        repeat (4) cycle();
        ce_k = 1'b0;
        repeat (5) cycle();
        ce_k = 1'b1;
        drain_all("freeze");
        seq_check("freeze");

        // Packet overflow: 17 flits without last, then a legal 16-flit packet
        rst_k = 1'b1; cycle(); rst_k = 1'b0;
        for (int k = 0; k < 17; k++) src_in.push_back(rand_flit(0));
        repeat (16) cycle();
        chk1("pkt_err_at_16", pkt_err, 1'b0);
        drain_all("pkt17");
        chk1("pkt_err_set", pkt_err, 1'b1);
        for (int k = 0; k < 16; k++) begin
            f = rand_flit(0);
            f[FW-1] = (k == 15);
            src_in.push_back(f);
        end
        drain_all("pkt16");
        chk1("pkt_err_sticky", pkt_err, 1'b1);
        seq_check("pkt");

        // Reset mid-operation discards buffered flits and clears pkt_err
        ob_pct = 100; mr_pct = 0;
        for (int k = 0; k < 3; k++) begin
            src_in.push_back(rand_flit(0));
            src_eg.push_back(rand_flit(0));
        end
        repeat (3) cycle();
        rst_k = 1'b1; cycle(); rst_k = 1'b0;
        chk1("midrst_o_v", o_v, 1'b0);
        chk1("midrst_m_valid", m_axis_wvalid, 1'b0);
        chk1("midrst_pkt_err", pkt_err, 1'b0);
        src_in.delete(); src_eg.delete();
        sent_in.delete(); got_in.delete(); sent_eg.delete(); got_eg.delete();

        // Randomized traffic with occasional ce drops
        gap_pct = 30; ob_pct = 30; mr_pct = 70;
        for (int c = 0; c < 400; c++) begin
            if (src_in.size() < 3) src_in.push_back(rand_flit(10));
            if (src_eg.size() < 3) src_eg.push_back(rand_flit(20));
            ce_k = ($urandom_range(9) != 0);
            cycle();
        end
        drain_all("random");
        seq_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
